// File: rtl/wb_sdram_bridge_if.sv
// wb_sdram_bridge_if: Wishbone slave-side bus bundle for the SDRAM bridge
interface wb_sdram_bridge_if;
  logic        i_wbs_cyc;
  logic        i_wbs_stb;
  logic        i_wbs_we;
  logic [3:0]  i_wbs_sel;
  logic [31:0] i_wbs_adr;
  logic [31:0] i_wbs_dat;
  logic [31:0] o_wbs_dat;
  logic        o_wbs_ack;
  modport master (
    output i_wbs_cyc, i_wbs_stb, i_wbs_we, i_wbs_sel, i_wbs_adr, i_wbs_dat,
    input  o_wbs_dat, o_wbs_ack
  );
  modport slave (
    input  i_wbs_cyc, i_wbs_stb, i_wbs_we, i_wbs_sel, i_wbs_adr, i_wbs_dat,
    output o_wbs_dat, o_wbs_ack
  );
endinterface

// File: rtl/wb_sdram_bridge.sv
// wb_sdram_bridge: Wishbone slave turning bus cycles into SDRAM burst commands and FIFO traffic
module wb_sdram_bridge #(
  parameter int ADDR_WIDTH = 22,
  parameter int RD_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_sdram_bridge_if.slave      wbs,
  output logic                  o_rd_timeout,
  output logic                  wr_fifo_wr,
  output logic [31:0]           wr_fifo_data,
  output logic [3:0]            wr_fifo_mask,
  input  logic                  wr_fifo_full,
  output logic                  rd_fifo_rd,
  input  logic [31:0]           rd_fifo_data,
  input  logic                  rd_fifo_empty,
  output logic                  rd_fifo_reset,
  output logic                  write_en,
  output logic                  read_en,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic                  sdram_ready
);
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WRITE, RD_FLUSH, RD_WAIT, RD_DATA, HOLD} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, nxt_q, nxt_d, word;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           dat_q, dat_d;
  logic                  wen_q, wen_d, ren_q, ren_d, ack_q, ack_d, to_q, to_d, low_q, low_d;
  logic                  req, cont, unused_adr;
  assign req = wbs.i_wbs_cyc & wbs.i_wbs_stb;
  assign word = wbs.i_wbs_adr[ADDR_WIDTH+1:2];
  assign unused_adr = ^{wbs.i_wbs_adr[31:ADDR_WIDTH+2], wbs.i_wbs_adr[1:0]};
  assign cont = (wbs.i_wbs_we ? wen_q : ren_q) && word == nxt_q;
  assign wbs.o_wbs_ack = ack_q;
  assign wbs.o_wbs_dat = dat_q;
  assign o_rd_timeout = to_q;
  assign write_en = wen_q;
  assign read_en = ren_q;
  assign address = addr_q;
  assign wr_fifo_data = wr_fifo_wr ? wbs.i_wbs_dat : '0;
  assign wr_fifo_mask = wr_fifo_wr ? ~wbs.i_wbs_sel : '0;
  // state and datapath registers; reset drops any burst on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      nxt_q   <= '0;
      cnt_q   <= '0;
      dat_q   <= '0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      ack_q   <= 1'b0;
      to_q    <= 1'b0;
      low_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      nxt_q   <= nxt_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      ack_q   <= ack_d;
      to_q    <= to_d;
      low_q   <= low_d;
    end
  end
  // next-state logic and FIFO/command strobes
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    nxt_d         = nxt_q;
    cnt_d         = cnt_q;
    dat_d         = dat_q;
    wen_d         = wen_q;
    ren_d         = ren_q;
    ack_d         = 1'b0;
    to_d          = 1'b0;
    low_d         = low_q;
    wr_fifo_wr    = 1'b0;
    rd_fifo_rd    = 1'b0;
    rd_fifo_reset = 1'b0;
    if (!wbs.i_wbs_cyc && state_q != IDLE) begin
      wen_d   = 1'b0;
      ren_d   = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (req && sdram_ready && !rst) begin
          addr_d        = word;
          wen_d         = wbs.i_wbs_we;
          ren_d         = !wbs.i_wbs_we;
          rd_fifo_reset = !wbs.i_wbs_we;
          state_d       = wbs.i_wbs_we ? WRITE : RD_FLUSH;
        end
        WRITE: if (wbs.i_wbs_stb && !wr_fifo_full) begin
          wr_fifo_wr = 1'b1;
          ack_d      = 1'b1;
          nxt_d      = word + ADDR_WIDTH'(1);
          low_d      = 1'b0;
          state_d    = HOLD;
        end
        RD_FLUSH: begin
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
        RD_WAIT: if (wbs.i_wbs_stb && !rd_fifo_empty) begin
          rd_fifo_rd = 1'b1;
          state_d    = RD_DATA;
        end else if (cnt_q == CW'(RD_TIMEOUT - 1)) begin
          ack_d   = 1'b1;
          to_d    = 1'b1;
          dat_d   = '0;
          ren_d   = 1'b0;
          low_d   = 1'b0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        RD_DATA: begin
          dat_d   = rd_fifo_data;
          ack_d   = 1'b1;
          nxt_d   = word + ADDR_WIDTH'(1);
          low_d   = 1'b0;
          state_d = HOLD;
        end
        HOLD: if (!wbs.i_wbs_stb) begin
          low_d = 1'b1;
        end else if (low_q && cont) begin
          cnt_d   = '0;
          state_d = wbs.i_wbs_we ? WRITE : RD_WAIT;
        end else if (low_q) begin
          wen_d   = 1'b0;
          ren_d   = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule
